digit_scan_ctrl: RTL and testbench

- Time-multiplexed 4-digit display scanner that drives a downstream active-low 2-to-4 decoder.
- Outputs `sel` and `dec_en` feed the decoder's `in` and `en` inputs.
- `digit_out` carries the nibble for the currently selected digit to the segment path.
- A double-buffered load port takes a new 16-bit value at any time; the value is committed only at a frame boundary so the display never tears.

---
 rtl/digit_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_digit_scan_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/digit_scan_ctrl.sv
// Four-digit display scanner that drives an active-low 2-to-4 decoder, with a double-buffered load port.
// Optional leading-zero blanking is enabled by defining DIGIT_SCAN_BLANK_LEADING_ZERO_EN.
module digit_scan_ctrl #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [1:0]  sel,
    output logic        dec_en,
    output logic [3:0]  digit_out,
    output logic        frame_done
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [15:0]        display;
    logic [15:0]        pending;
    logic               pending_full;

    logic               accept;
    logic               last_cnt;
    logic               wrap;
    logic [1:0]         sel_nx;
    logic               lit_nx;

    assign load_ready = ~pending_full;
    assign accept     = load_valid & ~pending_full;
    assign last_cnt   = (cnt == CNT_LAST);
    assign wrap       = (sel == 2'd3);
    assign sel_nx     = sel + 2'd1;

    // Whether the slot being entered is lit; digit 0 is always lit
    always_comb begin
        lit_nx = 1'b1;
`ifdef DIGIT_SCAN_BLANK_LEADING_ZERO_EN
        case (sel_nx)
            2'd1:    lit_nx = |display[15:4];
            2'd2:    lit_nx = |display[15:8];
            2'd3:    lit_nx = |display[15:12];
            default: lit_nx = 1'b1;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            display      <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            sel          <= 2'd0;
            dec_en       <= 1'b0;
            digit_out    <= 4'd0;
            frame_done   <= 1'b0;
        end else begin
            if (accept) begin
                pending      <= load_data;
                pending_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    sel        <= 2'd0;
                    cnt        <= '0;
                    frame_done <= 1'b0;
                    if (run) begin
                        state  <= SCAN;
                        dec_en <= 1'b1;
                        // A waiting word is committed as scanning starts
                        if (pending_full) begin
                            display      <= pending;
                            pending_full <= 1'b0;
                            digit_out    <= pending[3:0];
                        end else begin
                            digit_out <= display[3:0];
                        end
                    end else begin
                        dec_en <= 1'b0;
                    end
                end

                SCAN: begin
                    if (!run) begin
                        state      <= IDLE;
                        dec_en     <= 1'b0;
                        sel        <= 2'd0;
                        cnt        <= '0;
                        frame_done <= 1'b0;
                    end else if (last_cnt) begin
                        cnt        <= '0;
                        sel        <= sel_nx;
                        frame_done <= wrap;
                        // Commit only on the frame wrap so a frame never mixes two words
                        if (wrap && pending_full) begin
                            display      <= pending;
                            pending_full <= 1'b0;
                            digit_out    <= pending[3:0];
                            dec_en       <= 1'b1;
                        end else begin
                            digit_out <= display[{sel_nx, 2'b00} +: 4];
                            dec_en    <= lit_nx;
                        end
                    end else begin
                        cnt        <= cnt + CNT_W'(1);
                        frame_done <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed vector bench for digit_scan_ctrl: a PRESCALE=2 instance driven from a vector table,
// and a PRESCALE=1 instance exercising asynchronous reset mid-frame.
module tb_digit_scan_ctrl;

`ifdef DIGIT_SCAN_BLANK_LEADING_ZERO_EN
    localparam logic BL = 1'b0;
`else
    localparam logic BL = 1'b1;
`endif

    typedef struct {
        logic        run;
        logic        lv;
        logic [15:0] ld;
        logic [1:0]  sel;
        logic        en;
        logic [3:0]  dig;
        logic        fd;
        logic        rdy;
        logic        chk_dig;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst_n, a_run, a_lv, a_rdy, a_en, a_fd;
    logic [15:0] a_ld;
    logic [1:0]  a_sel;
    logic [3:0]  a_dig;

    logic        b_rst_n, b_run, b_lv, b_rdy, b_en, b_fd;
    logic [15:0] b_ld;
    logic [1:0]  b_sel;
    logic [3:0]  b_dig;

    digit_scan_ctrl #(.PRESCALE(2)) u_a (
        .clk(clk), .reset_n(a_rst_n), .run(a_run), .load_valid(a_lv), .load_data(a_ld),
        .load_ready(a_rdy), .sel(a_sel), .dec_en(a_en), .digit_out(a_dig), .frame_done(a_fd)
    );

    digit_scan_ctrl #(.PRESCALE(1)) u_b (
        .clk(clk), .reset_n(b_rst_n), .run(b_run), .load_valid(b_lv), .load_data(b_ld),
        .load_ready(b_rdy), .sel(b_sel), .dec_en(b_en), .digit_out(b_dig), .frame_done(b_fd)
    );

    int   passed = 0;
    int   total  = 0;
    vec_t vq[$];

    // Output bundle is {sel, dec_en, digit_out, frame_done, load_ready}
    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp,
                         input logic [8:0] mask);
        total++;
        if ((act & mask) === (exp & mask)) passed++;
        else $display("FAIL %s: got sel/en/dig/fd/rdy=%h/%b/%h/%b/%b want %h/%b/%h/%b/%b",
                      name, act[8:7], act[6], act[5:2], act[1], act[0],
                      exp[8:7], exp[6], exp[5:2], exp[1], exp[0]);
    endtask

    task automatic add(input logic run, input logic lv, input logic [15:0] ld,
                       input logic [1:0] sel, input logic en, input logic [3:0] dig,
                       input logic fd, input logic rdy, input logic cd);
        vec_t v;
        v.run = run; v.lv = lv; v.ld = ld; v.sel = sel; v.en = en;
        v.dig = dig; v.fd = fd; v.rdy = rdy; v.chk_dig = cd;
        vq.push_back(v);
    endtask

    initial begin
        a_rst_n = 1'b0; a_run = 1'b0; a_lv = 1'b0; a_ld = '0;
        b_rst_n = 1'b0; b_run = 1'b0; b_lv = 1'b0; b_ld = '0;

        // First frame with display=0
        add(0,0,16'h0000, 0,0, 4'h0,0,1,1);
        add(1,0,16'h0000, 0,1, 4'h0,0,1,1);
        add(1,0,16'h0000, 0,1, 4'h0,0,1,1);
        add(1,0,16'h0000, 1,BL,4'h0,0,1,1);
        add(1,0,16'h0000, 1,BL,4'h0,0,1,1);
        add(1,0,16'h0000, 2,BL,4'h0,0,1,1);
        add(1,0,16'h0000, 2,BL,4'h0,0,1,1);
        add(1,0,16'h0000, 3,BL,4'h0,0,1,1);
        add(1,0,16'h0000, 3,BL,4'h0,0,1,1);
        add(1,0,16'h0000, 0,1, 4'h0,1,1,1);
        add(1,0,16'h0000, 0,1, 4'h0,0,1,1);
        // Mid-frame load of 4321
        add(1,1,16'h4321, 1,BL,4'h0,0,0,1);
        add(1,0,16'h0000, 1,BL,4'h0,0,0,1);
        add(1,0,16'h0000, 2,BL,4'h0,0,0,1);
        add(1,0,16'h0000, 2,BL,4'h0,0,0,1);
        add(1,0,16'h0000, 3,BL,4'h0,0,0,1);
        add(1,0,16'h0000, 3,BL,4'h0,0,0,1);
        add(1,0,16'h0000, 0,1, 4'h1,1,1,1);
        add(1,0,16'h0000, 0,1, 4'h1,0,1,1);
        add(1,0,16'h0000, 1,1, 4'h2,0,1,1);
        add(1,0,16'h0000, 1,1, 4'h2,0,1,1);
        add(1,0,16'h0000, 2,1, 4'h3,0,1,1);
        add(1,0,16'h0000, 2,1, 4'h3,0,1,1);
        add(1,0,16'h0000, 3,1, 4'h4,0,1,1);
        add(1,0,16'h0000, 3,1, 4'h4,0,1,1);
        add(1,0,16'h0000, 0,1, 4'h1,1,1,1);
        // AAAA accepted, BBBB held off until after the wrap
        add(1,1,16'hAAAA, 0,1, 4'h1,0,0,1);
        add(1,1,16'hBBBB, 1,1, 4'h2,0,0,1);
        add(1,1,16'hBBBB, 1,1, 4'h2,0,0,1);
        add(1,1,16'hBBBB, 2,1, 4'h3,0,0,1);
        add(1,1,16'hBBBB, 2,1, 4'h3,0,0,1);
        add(1,1,16'hBBBB, 3,1, 4'h4,0,0,1);
        add(1,1,16'hBBBB, 3,1, 4'h4,0,0,1);
        add(1,1,16'hBBBB, 0,1, 4'hA,1,1,1);
        add(1,1,16'hBBBB, 0,1, 4'hA,0,0,1);
        add(1,0,16'h0000, 1,1, 4'hA,0,0,1);
        add(1,0,16'h0000, 1,1, 4'hA,0,0,1);
        add(1,0,16'h0000, 2,1, 4'hA,0,0,1);
        add(1,0,16'h0000, 2,1, 4'hA,0,0,1);
        add(1,0,16'h0000, 3,1, 4'hA,0,0,1);
        add(1,0,16'h0000, 3,1, 4'hA,0,0,1);
        add(1,0,16'h0000, 0,1, 4'hB,1,1,1);
        add(1,0,16'h0000, 0,1, 4'hB,0,1,1);
        add(1,0,16'h0000, 1,1, 4'hB,0,1,1);
        add(1,0,16'h0000, 1,1, 4'hB,0,1,1);
        add(1,0,16'h0000, 2,1, 4'hB,0,1,1);
        // run drops at sel=2, word loaded while idle, committed on restart
        add(0,0,16'h0000, 0,0, 4'h0,0,1,0);
        add(0,1,16'h0765, 0,0, 4'h0,0,0,0);
        add(0,0,16'h0000, 0,0, 4'h0,0,0,0);
        add(1,0,16'h0000, 0,1, 4'h5,0,1,1);
        add(1,0,16'h0000, 0,1, 4'h5,0,1,1);
        add(1,0,16'h0000, 1,1, 4'h6,0,1,1);
        add(1,0,16'h0000, 1,1, 4'h6,0,1,1);
        add(1,0,16'h0000, 2,1, 4'h7,0,1,1);
        add(1,0,16'h0000, 2,1, 4'h7,0,1,1);
        add(1,0,16'h0000, 3,BL,4'h0,0,1,1);
        add(1,0,16'h0000, 3,BL,4'h0,0,1,1);
        add(1,0,16'h0000, 0,1, 4'h5,1,1,1);
        // 0070: only the upper two slots are leading zeros
        add(1,1,16'h0070, 0,1, 4'h5,0,0,1);
        add(1,0,16'h0000, 1,1, 4'h6,0,0,1);
        add(1,0,16'h0000, 1,1, 4'h6,0,0,1);
        add(1,0,16'h0000, 2,1, 4'h7,0,0,1);
        add(1,0,16'h0000, 2,1, 4'h7,0,0,1);
        add(1,0,16'h0000, 3,BL,4'h0,0,0,1);
        add(1,0,16'h0000, 3,BL,4'h0,0,0,1);
        add(1,0,16'h0000, 0,1, 4'h0,1,1,1);
        add(1,0,16'h0000, 0,1, 4'h0,0,1,1);
        add(1,0,16'h0000, 1,1, 4'h7,0,1,1);
        add(1,0,16'h0000, 1,1, 4'h7,0,1,1);
        add(1,0,16'h0000, 2,BL,4'h0,0,1,1);
        add(1,0,16'h0000, 2,BL,4'h0,0,1,1);
        add(1,0,16'h0000, 3,BL,4'h0,0,1,1);
        add(1,0,16'h0000, 3,BL,4'h0,0,1,1);
        add(1,0,16'h0000, 0,1, 4'h0,1,1,1);

        #12;
        check("a_reset", {a_sel, a_en, a_dig, a_fd, a_rdy}, {2'd0, 1'b0, 4'h0, 1'b0, 1'b1}, 9'h1FF);
        check("b_reset", {b_sel, b_en, b_dig, b_fd, b_rdy}, {2'd0, 1'b0, 4'h0, 1'b0, 1'b1}, 9'h1FF);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            a_run = vq[i].run; a_lv = vq[i].lv; a_ld = vq[i].ld;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), {a_sel, a_en, a_dig, a_fd, a_rdy},
                  {vq[i].sel, vq[i].en, vq[i].dig, vq[i].fd, vq[i].rdy},
                  vq[i].chk_dig ? 9'h1FF : 9'h1C3);
        end
        a_run = 1'b0; a_lv = 1'b0;

        // PRESCALE=1: load 1234 while idle, start, then load again and reset mid-frame
        b_lv = 1'b1; b_ld = 16'h1234;
        @(posedge clk); #1;
        b_lv = 1'b0; b_run = 1'b1;
        @(posedge clk); #1;
        check("b_start", {b_sel, b_en, b_dig, b_fd, b_rdy}, {2'd0, 1'b1, 4'h4, 1'b0, 1'b1}, 9'h1FF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("b_sel2", {b_sel, b_en, b_dig, b_fd, b_rdy}, {2'd2, 1'b1, 4'h2, 1'b0, 1'b1}, 9'h1FF);
        b_lv = 1'b1; b_ld = 16'h5678;
        @(posedge clk); #1;
        b_lv = 1'b0;
        check("b_sel3_pend", {b_sel, b_en, b_dig, b_fd, b_rdy}, {2'd3, 1'b1, 4'h1, 1'b0, 1'b0}, 9'h1FF);
        #3;
        b_rst_n = 1'b0;
        #1;
        check("b_async_rst", {b_sel, b_en, b_dig, b_fd, b_rdy}, {2'd0, 1'b0, 4'h0, 1'b0, 1'b1}, 9'h1FF);
        #2;
        b_rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            check($sformatf("b_scan%0d", i), {b_sel, b_en, b_dig, b_fd, b_rdy},
                  {2'(i), ((i % 4) == 0) ? 1'b1 : BL, 4'h0, (i == 4 || i == 8), 1'b1}, 9'h1FF);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
